// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream_fifo buffer: RAM style names, level-width
// helper and a status bundle for upstream status buses.
package stream_fifo_pkg;

  localparam string RAM_DISTRIBUTED = "distributed";
  localparam string RAM_BLOCK       = "block";

  // Status buses carry the level in a fixed-width field so that FIFOs of
  // different depths can share one bus type.
  localparam int STATUS_LVL_W = 16;

  typedef struct packed {
    logic                    almost_full;
    logic                    almost_empty;
    logic [STATUS_LVL_W-1:0] level;
  } stream_fifo_status_t;

  // Level must represent 0..FIFO_DEPTH+1 (output register adds one word).
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage for stream_fifo. REG_READ=0 gives a combinational
// read; REG_READ=1 gives a read register that only loads on rd_en and holds
// otherwise (block RAM inferable, read-first on an address collision).
module stream_fifo_ram
  import stream_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    FIFO_DEPTH = 32,
  parameter string RAM_TYPE   = RAM_DISTRIBUTED,
  parameter int    REG_READ   = 0,
  localparam int   ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Write port: no reset, contents survive flush and reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (REG_READ != 0) begin : g_reg_read
    // Registered read: holds the last word until the next rd_en.
    always_ff @(posedge i_clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end else begin : g_async_read
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    // Combinational read of the addressed word.
    always_comb rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FWFT FIFO with valid/ready on both sides,
// runtime almost-full/almost-empty thresholds, level output and flush.
// Optional build macro STREAM_FIFO_OUT_REG_EN: the RAM read register becomes
// the output register (capacity FIFO_DEPTH+1, write-to-read latency 2).
// Without it the head is a combinational memory read (capacity FIFO_DEPTH,
// latency 1) and RAM_TYPE must stay "distributed".
//
// Handshake: a word moves on a rising edge where valid & ready are both high
// on that side; valid never waits on ready, o_s_ready comes from registered
// state plus i_flush only, and o_m_data holds while o_m_valid & ~i_m_ready.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    FIFO_DEPTH = 32,
  parameter string RAM_TYPE   = RAM_DISTRIBUTED,
  localparam int   PTR_W      = $clog2(FIFO_DEPTH),
  localparam int   LVL_W      = lvl_w(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst_n,
  input  logic                  i_flush,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready,
  input  logic [LVL_W-1:0]      i_af_thr,
  input  logic [LVL_W-1:0]      i_ae_thr,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [LVL_W-1:0]      o_level
);

`ifdef STREAM_FIFO_OUT_REG_EN
  localparam int CAP_WORDS = FIFO_DEPTH + 1;
  localparam int REG_READ  = 1;
`else
  localparam int CAP_WORDS = FIFO_DEPTH;
  localparam int REG_READ  = 0;
`endif
  localparam logic [LVL_W-1:0] CAP = LVL_W'(CAP_WORDS);

  logic                  rst_done;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // Explicit wrap so any depth works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_s_ready = rst_done & ~i_flush & (level != CAP);
  assign push      = i_s_valid & o_s_ready;
  assign pop       = o_m_valid & i_m_ready & ~i_flush;

`ifdef STREAM_FIFO_OUT_REG_EN
  logic out_valid;

  // Refill the output register whenever memory holds a word beyond the one
  // already presented and the register is empty or being drained.
  assign rd_en     = ~i_flush & (level > LVL_W'(out_valid)) & (~out_valid | pop);
  assign o_m_valid = out_valid;

  // Output register valid: set on refill, cleared on an unrefilled pop.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n)   out_valid <= 1'b0;
    else if (i_flush) out_valid <= 1'b0;
    else if (rd_en)   out_valid <= 1'b1;
    else if (pop)     out_valid <= 1'b0;
  end
`else
  assign rd_en     = pop;
  assign o_m_valid = (level != '0);
`endif

  assign o_m_data = rd_data;

  // Ready is withheld until one edge after reset release.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) rst_done <= 1'b0;
    else            rst_done <= 1'b1;
  end

  // Pointer advance; flush returns both to zero.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Held-word count, including any word sitting in the output register.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n)        level <= '0;
    else if (i_flush)      level <= '0;
    else if (push && !pop) level <= level + 1'b1;
    else if (!push && pop) level <= level - 1'b1;
  end

  assign o_level        = level;
  assign o_almost_full  = (level >= i_af_thr);
  assign o_almost_empty = (level <= i_ae_thr);

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RAM_TYPE   (RAM_TYPE),
    .REG_READ   (REG_READ)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised single-clock FIFO with valid/ready streaming handshakes on both sides, first-word-fall-through output, runtime almost-full/almost-empty thresholds, fill-level output and synchronous flush. It is the next-generation buffer between streaming producers and consumers in the PL datapath. Handshakes make overflow and underflow structurally impossible, and the block supports any depth, not only powers of two.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- FIFO_DEPTH, 32, memory words (≥2, any integer)
- RAM_TYPE, "distributed", ram_style of storage; "block" is legal only with STREAM_FIFO_OUT_REG_EN
- Derived: PTR_W = $clog2(FIFO_DEPTH); LVL_W = $clog2(FIFO_DEPTH+2)

- i_clk  in  1  clock, all logic on rising edge
- i_a_rst_n  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous flush, one-cycle pulse or level
- i_s_valid  in  1  write data valid
- i_s_data  in  DATA_WIDTH  write data
- o_s_ready  out  1  FIFO can accept a word
- o_m_valid  out  1  head word valid
- o_m_data  out  DATA_WIDTH  head word (FWFT)
- i_m_ready  in  1  consumer takes the head word
- i_af_thr  in  LVL_W  almost-full threshold
- i_ae_thr  in  LVL_W  almost-empty threshold
- o_almost_full  out  1  o_level ≥ i_af_thr
- o_almost_empty  out  1  o_level ≤ i_ae_thr
- o_level  out  LVL_W  words currently held

## Operation
- Push on an edge with i_s_valid & o_s_ready. Pop on an edge with o_m_valid & i_m_ready.
- The storage memory uses wr_ptr/rd_ptr of PTR_W bits. Each pointer wraps explicitly from FIFO_DEPTH-1 to 0.
- o_level tracks held words as +1 on push only, −1 on pop only, unchanged on both or neither. It never exceeds CAP.
- CAP = FIFO_DEPTH without the macro, FIFO_DEPTH+1 with it.
- o_s_ready = rst_done & ~i_flush & (o_level != CAP). It is registered-state driven. There is no pass-through when full: a simultaneous pop does not enable a push in the same cycle.
- rst_done is a flop cleared by reset and set on the first edge after release.
- Flush has priority over push and pop in the same cycle. It zeroes the pointers, o_level and the output-register valid. Memory contents are untouched.
- o_almost_full and o_almost_empty are combinational compares against the registered o_level. Threshold changes take effect in the same cycle.
- Reset values: o_s_ready 0, o_m_valid 0, o_level 0, o_almost_full = (i_af_thr==0), o_almost_empty 1. o_m_data is don't-care while o_m_valid is 0.
- Reset asserted mid-transfer discards all contents immediately (asynchronous).
- The consumer may drop i_m_ready at any time. o_m_data is stable while o_m_valid & ~i_m_ready.

## Timing
- Without macro: o_m_data = mem[rd_ptr] is a combinational read, and o_m_valid = (o_level != 0). A push to an empty FIFO at edge k gives o_m_valid high after edge k, so write-to-read latency is 1 cycle.
- With macro: o_m_data and o_m_valid come from an output register, refilled from memory via a registered read. A push to an empty FIFO at edge k gives o_m_valid after edge k+1 (latency 2). Back-to-back pops sustain one word per cycle.
- o_s_ready rises the cycle after the first edge following reset release.
- Pop throughput is 1 word/cycle. Push throughput is 1 word/cycle while below CAP.

## Configuration
- STREAM_FIFO_OUT_REG_EN defined: adds the output register and prefetch control, and uses a registered memory read (block RAM inferable). CAP = FIFO_DEPTH+1, latency 2.
- Not defined: no output register and asynchronous memory read. RAM_TYPE must be "distributed". CAP = FIFO_DEPTH, latency 1.
- Ports are identical in both builds.

## Structure
- stream_fifo_pkg holds:
  - the level-width function lvl_w(depth) = $clog2(depth+2);
  - the RAM_TYPE string constants;
  - a typedef stream_fifo_status_t {almost_full, almost_empty, level} for upstream status buses.
- Sub-module stream_fifo_ram: simple dual-port RAM with DATA_WIDTH, FIFO_DEPTH, RAM_TYPE and parameter REG_READ (0 async, 1 registered). The write is unconditional on the write-enable, with no reset.

## Test plan
- Reset then fill: DATA_WIDTH=8, FIFO_DEPTH=5, push 0x01..0x06 continuously with i_m_ready=0.
  - Without macro: o_s_ready drops after 5 words, o_level=5.
  - With macro: o_s_ready drops after 6 words, o_level=6.
- Drain order and wrap: after the fill, i_m_ready=1 and push 0x10..0x1F concurrently. Output is strictly 0x01..0x05(0x06) then 0x10..0x1F, with no gaps after the first word. Pointers wrap 4→0 with no loss.
- Latency:
  - Single push 0xA5 to an empty FIFO at edge k gives o_m_valid=1, o_m_data=0xA5 after edge k (no macro) or after edge k+1 (macro).
  - o_level reads 1 after edge k in both builds.
- Thresholds: i_af_thr=3, i_ae_thr=1.
  - Levels 0,1,2,3,4 give almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1.
  - Changing i_af_thr to 2 at level 2 raises o_almost_full the same cycle.
- Flush with simultaneous push/pop at level 3: after the edge, o_level=0, o_m_valid=0 and the pushed word is discarded. The next push of 0x77 is the next word out.
- Asynchronous reset mid-stream: assert i_a_rst_n low between edges at level 4.
  - o_m_valid, o_s_ready and o_level go to 0 immediately.
  - After release, o_s_ready=1 one edge later and the FIFO is empty.
